// File: rtl/cnn_layer_sequencer.sv
// Frame-level scheduler for the conv -> relu -> maxpool -> dense chain: launches each
// layer engine in turn, watches for its done pulse, and times out a stalled stage.
module cnn_layer_sequencer #(
   parameter int NUM_STAGES     = 4,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  frame_start,
   output logic                                  frame_ready,
   input  logic                                  abort,
   input  logic                                  clear_err,
   output logic [NUM_STAGES-1:0]                 stage_start,
   input  logic [NUM_STAGES-1:0]                 stage_done,
   output logic                                  busy,
   output logic                                  result_valid,
   output logic                                  error,
   output logic [$clog2(NUM_STAGES+1)-1:0]       err_stage,
   output logic [CNT_WIDTH-1:0]                  cycle_count
);

   localparam int IDX_W = $clog2(NUM_STAGES + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FINISH, ERROR} state_t;

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [WD_W-1:0]   watchdog;
   logic              cur_done;
   logic              last_stage;
   logic              in_frame;
   logic              wd_expired;

   // Only the done bit of the stage currently being waited on matters.
   assign cur_done   = |(stage_done & (NUM_STAGES'(1) << idx));
   assign last_stage = (idx == IDX_W'(NUM_STAGES - 1));
   assign in_frame   = (state == LAUNCH) || (state == WAIT) || (state == FINISH);
   assign wd_expired = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         idx          <= '0;
         watchdog     <= '0;
         stage_start  <= '0;
         result_valid <= 1'b0;
         error        <= 1'b0;
         err_stage    <= '0;
         cycle_count  <= '0;
         frame_ready  <= 1'b1;
         busy         <= 1'b0;
      end else begin
         stage_start  <= '0;
         result_valid <= 1'b0;
         if (in_frame && (cycle_count != '1))
            cycle_count <= cycle_count + 1'b1;

         case (state)
            IDLE: begin
               if (frame_start) begin
                  idx         <= '0;
                  cycle_count <= '0;
                  stage_start <= NUM_STAGES'(1);
                  frame_ready <= 1'b0;
                  busy        <= 1'b1;
                  state       <= LAUNCH;
               end
            end
            LAUNCH: begin
               watchdog <= '0;
               if (abort) begin
                  frame_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  state <= WAIT;
               end
            end
            WAIT: begin
               watchdog <= watchdog + 1'b1;
               // Abort outranks both a final done and a timeout in the same cycle.
               if (abort) begin
                  frame_ready <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else if (cur_done) begin
                  if (last_stage) begin
                     result_valid <= 1'b1;
                     state        <= FINISH;
                  end else begin
                     idx         <= idx + 1'b1;
                     stage_start <= NUM_STAGES'(1) << (idx + 1'b1);
                     state       <= LAUNCH;
                  end
               end else if (wd_expired) begin
                  err_stage <= idx;
                  error     <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ERROR;
               end
            end
            FINISH: begin
               frame_ready <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            ERROR: begin
               if (clear_err) begin
                  error       <= 1'b0;
                  frame_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               frame_ready <= 1'b1;
               busy        <= 1'b0;
               error       <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule
